// File: rtl/pe_traffic_gen_if.sv
// rtl/pe_traffic_gen_if.sv - injection-port handshake bundle between traffic source and NoC
// Carries the packet word plus its valid/ready pair; master drives data/valid.
interface pe_traffic_gen_if #(
  parameter int TotalWidth = 35
);
  logic [TotalWidth-1:0] o_data;
  logic                  o_data_valid;
  logic                  i_data_ready;

  modport master (
    output o_data,
    output o_data_valid,
    input  i_data_ready
  );

  modport slave (
    input  o_data,
    input  o_data_valid,
    output i_data_ready
  );
endinterface

// File: rtl/pe_traffic_gen.sv
// rtl/pe_traffic_gen.sv - pattern-driven packet source for one HNoC injection port
// Emits PktLmit packets {dest, src, timestamp} over valid/ready; every output is registered.
module pe_traffic_gen #(
  parameter int          address      = 0,
  parameter int          numPE        = 8,
  parameter int          AddressWidth = 3,
  parameter int          DataWidth    = 32,
  parameter int          TotalWidth   = 35,
  parameter int          PktLmit      = 100,
  parameter string       Pattern      = "Tornado",
  parameter int          Gap          = 0,
  parameter logic [15:0] Seed         = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic                 i_stop,
  pe_traffic_gen_if.master     bus,
  output logic [15:0]          o_sent_count,
  output logic                 o_done
);

  localparam int TsWidth = DataWidth - AddressWidth;

  // Pattern selector decoded once at elaboration
  localparam int PAT_UNIFORM    = 0;
  localparam int PAT_TORNADO    = 1;
  localparam int PAT_COMPLEMENT = 2;
  localparam int PAT_NEIGHBOUR  = 3;
  localparam int PAT = (Pattern == "Uniform")    ? PAT_UNIFORM :
                       (Pattern == "Complement") ? PAT_COMPLEMENT :
                       (Pattern == "Neighbour")  ? PAT_NEIGHBOUR : PAT_TORNADO;

  // Fixed destinations for the deterministic patterns
  localparam logic [AddressWidth-1:0] ADDR         = AddressWidth'(address);
  localparam logic [AddressWidth-1:0] DEST_TORNADO = AddressWidth'((address + numPE / 2 - 1) % numPE);
  localparam logic [AddressWidth-1:0] DEST_COMP    = ~ADDR;
  localparam logic [AddressWidth-1:0] DEST_NEIGH   = AddressWidth'((address + 1) % numPE);

  localparam bit          NO_GAP   = (Gap == 0);
  localparam logic [7:0]  GAP_LOAD = 8'(Gap);
  localparam logic [15:0] PKT_LMIT = 16'(PktLmit);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [TotalWidth-1:0]  r_data;
  logic                   r_valid;
  logic [15:0]            r_sent_count;
  logic                   r_done;
  logic [15:0]            r_lfsr;
  logic [TsWidth-1:0]     r_cycle;
  logic [7:0]             r_gap_cnt;
  logic                   r_stop_pend;

  logic [15:0]            w_lfsr_next;
  logic [AddressWidth-1:0] w_dest;
  logic [TotalWidth-1:0]  w_pkt;
  logic                   w_xfer;
  logic [15:0]            w_count_inc;
  logic                   w_last;
  logic                   w_stop;

  // Fibonacci LFSR, taps 16,14,13,11; advanced once per packet
  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  // Destination of the packet about to be formed; uniform never targets itself
  always_comb begin
    w_dest = DEST_TORNADO;
    case (PAT)
      PAT_UNIFORM: begin
        w_dest = w_lfsr_next[AddressWidth-1:0];
        if (w_dest == ADDR) w_dest = DEST_NEIGH;
      end
      PAT_COMPLEMENT: w_dest = DEST_COMP;
      PAT_NEIGHBOUR:  w_dest = DEST_NEIGH;
      default:        w_dest = DEST_TORNADO;
    endcase
  end

  assign w_pkt       = {w_dest, ADDR, r_cycle};
  assign w_xfer      = r_valid & bus.i_data_ready;
  assign w_count_inc = r_sent_count + 16'd1;
  assign w_last      = (w_count_inc == PKT_LMIT);
  // A stop seen while a packet is pending is remembered until that packet goes
  assign w_stop      = i_stop | r_stop_pend;

  // Free-running timestamp source, wraps silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
    end
  end

  // Packet state machine; all handshake and status outputs come from here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_sent_count <= '0;
      r_done       <= 1'b0;
      r_lfsr       <= Seed;
      r_gap_cnt    <= '0;
      r_stop_pend  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_stop) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (i_enable) begin
            r_state <= S_SEND;
            r_data  <= w_pkt;
            r_lfsr  <= w_lfsr_next;
            r_valid <= 1'b1;
          end
        end

        S_SEND: begin
          if (i_stop) r_stop_pend <= 1'b1;
          if (w_xfer) begin
            r_sent_count <= w_count_inc;
            if (w_last || w_stop) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else if (NO_GAP) begin
              r_data  <= w_pkt;
              r_lfsr  <= w_lfsr_next;
            end else begin
              r_state   <= S_GAP;
              r_valid   <= 1'b0;
              r_gap_cnt <= GAP_LOAD;
            end
          end
        end

        S_GAP: begin
          if (i_stop) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (i_enable) begin
            if (r_gap_cnt <= 8'd1) begin
              r_state <= S_SEND;
              r_data  <= w_pkt;
              r_lfsr  <= w_lfsr_next;
              r_valid <= 1'b1;
            end else begin
              r_gap_cnt <= r_gap_cnt - 8'd1;
            end
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_done  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_data       = r_data;
  assign bus.o_data_valid = r_valid;
  assign o_sent_count     = r_sent_count;
  assign o_done           = r_done;

endmodule
